// File: rtl/serial_deser_en_pkg.sv
// Shared types and constants for the serial deserializer.
// The parity frame format is enabled with SERIAL_DESER_PARITY_EN.
package serial_deser_en_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_PAR  = 2'd2
   } state_t;

   // Counter width needed to hold frame positions 0..width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-N up counter with synchronous reset, clear and enable.
// tc flags the last count value so the caller can close a frame.
module serial_bit_counter
   import serial_deser_en_pkg::*;
#(
   parameter int N = DEFAULT_WIDTH,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] r_cnt;

   assign tc  = (r_cnt == W'(N - 1));
   assign cnt = r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (tc) r_cnt <= '0;
         else    r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_deser_en.sv
// MSB-first serial-to-parallel deserializer with a one-cycle valid strobe.
// Define SERIAL_DESER_PARITY_EN for WIDTH data bits plus one even-parity bit.
module serial_deser_en
   import serial_deser_en_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
`ifdef SERIAL_DESER_PARITY_EN
   localparam int FRAME = WIDTH + 1,
`else
   localparam int FRAME = WIDTH,
`endif
   localparam int BC_W = $clog2(FRAME)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             d,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             busy,
`ifdef SERIAL_DESER_PARITY_EN
   output logic             parity_err,
`endif
   output logic [BC_W-1:0]  bit_cnt
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_shreg;
   logic [WIDTH-1:0]   r_dout;
   logic               r_valid;
   logic [WIDTH-1:0]   w_shift;
   logic [BC_W-1:0]    w_cnt;
   logic               w_tc;

   assign w_shift = {r_shreg[WIDTH-2:0], d};

   serial_bit_counter #(
      .N (FRAME),
      .W (BC_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .cnt   (w_cnt),
      .tc    (w_tc)
   );

`ifdef SERIAL_DESER_PARITY_EN
   logic r_parity_err;
   logic w_last_data;

   assign w_last_data = (w_cnt == BC_W'(WIDTH - 1));
   assign parity_err  = r_parity_err;
`endif

   // Priority reset > clr > en; valid defaults low so it pulses for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (clr) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
         end else if (en) begin
            case (r_state)
               ST_IDLE: begin
                  r_shreg <= w_shift;
                  r_state <= ST_RECV;
               end
               ST_RECV: begin
                  r_shreg <= w_shift;
`ifdef SERIAL_DESER_PARITY_EN
                  if (w_last_data) r_state <= ST_PAR;
`else
                  if (w_tc) begin
                     r_dout  <= w_shift;
                     r_valid <= 1'b1;
                     r_state <= ST_IDLE;
                  end
`endif
               end
`ifdef SERIAL_DESER_PARITY_EN
               // The parity bit is checked but never shifted into the word.
               ST_PAR: begin
                  if (w_tc) begin
                     r_dout       <= r_shreg;
                     r_parity_err <= ^{r_shreg, d};
                     r_valid      <= 1'b1;
                     r_state      <= ST_IDLE;
                  end
               end
`endif
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign dout    = r_dout;
   assign valid   = r_valid;
   assign busy    = (r_state != ST_IDLE);
   assign bit_cnt = w_cnt;

endmodule
